// File: rtl/ahb_sram_slave_if.sv
// ahb_intf: AHB-Lite bus between one master (or interconnect) and one subordinate.
interface ahb_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTERLOCK;
    logic                  HREADYIN;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK, HREADYIN,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK, HREADYIN,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate backed by a word-addressed register-array memory.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES stall cycles before every OKAY data phase.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input logic     HCLK,
    input logic     HRESET,
    ahb_intf.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;

    state_t                state, nxt, ok_state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IW-1:0]         idx_q;
    logic [LB-1:0]         off_q;
    logic [2:0]            size_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] word;
    logic [7:0]            amask;
    logic                  acc, err, wait_done;

    assign word  = bus.HADDR >> LB;
    assign amask = (8'd1 << bus.HSIZE) - 8'd1;
    assign acc   = bus.HSEL && bus.HREADYIN && bus.HTRANS[1] && state inside {IDLE, DATA, ERR2};
    assign err   = word >= ADDR_WIDTH'(MEM_DEPTH) || bus.HSIZE > 3'(LB) || |(bus.HADDR[7:0] & amask);

`ifdef AHB_SLV_WAIT_EN
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
    logic [CW-1:0] cnt;
    assign wait_done = cnt == '0;
    assign ok_state  = WAIT_STATES > 0 ? WAIT : DATA;
    // Reloaded whenever not stalling, so each WAIT entry starts from a full count.
    always_ff @(posedge HCLK)
        cnt <= state == WAIT ? cnt - 1'b1 : CW'(WAIT_STATES - 1);
    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTERLOCK};
`else
    assign wait_done = 1'b1;
    assign ok_state  = DATA;
    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTERLOCK, WAIT_STATES != 0};
`endif

    always_ff @(posedge HCLK)
        state <= HRESET ? IDLE : nxt;

    always_comb
        nxt = state == ERR1 ? ERR2 :
              state == WAIT ? (wait_done ? DATA : WAIT) :
              acc           ? (err ? ERR1 : ok_state) : IDLE;

    always_comb begin
        bus.HREADYOUT = !(state == WAIT || state == ERR1);
        bus.HRESP     = state == ERR1 || state == ERR2;
        bus.HRDATA    = (state == DATA && !wr_q) ? mem[idx_q] : '0;
    end

    // Only the 2**size lanes starting at the captured byte offset are committed.
    always_ff @(posedge HCLK) begin
        if (acc) begin
            idx_q  <= word[IW-1:0];
            off_q  <= bus.HADDR[LB-1:0];
            size_q <= bus.HSIZE;
            wr_q   <= bus.HWRITE;
        end
        if (!HRESET && state == DATA && wr_q)
            for (int b = 0; b < NB; b++)
                if (b >= int'(off_q) && b < int'(off_q) + (1 << size_q))
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed plus randomized AHB-Lite traffic against a byte-array memory model.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    localparam int DEPTH = 256;
`ifdef AHB_SLV_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic HCLK = 0;
    logic HRESET = 1;
    ahb_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );
    always #5 HCLK = ~HCLK;

    int          n_chk, n_fail;
    logic [7:0]  mb [DEPTH*4];
    xfer_t       q[$];
    xfer_t       dp, idle_x;
    bit          dv, rnd;
    int          age;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_err(xfer_t t);
        return (t.addr / 4) >= DEPTH || t.size > 2 || (t.addr % (32'd1 << t.size)) != 0;
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] a);
        int b = int'(a & ~32'h3);
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    task automatic commit(xfer_t t);
        for (int i = 0; i < (1 << t.size); i++)
            mb[t.addr + i] = t.wdata[8*(int'(t.addr % 4) + i) +: 8];
    endtask

    function automatic xfer_t mk(logic wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
        xfer_t t;
        t.sel = 1; t.trans = 2'b10; t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata;
        return t;
    endfunction

    function automatic xfer_t rand_x();
        xfer_t t = mk(1'($urandom), 32'($urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(0, 1023)),
                      3'($urandom_range(0, 2)), $urandom);
        int r = $urandom_range(0, 99);
        t.addr &= ~((32'd1 << t.size) - 1);
        if (r < 8) t.addr = 32'($urandom_range(0, 1023));
        else if (r < 14) t.addr = 32'h400 + 32'($urandom_range(0, 255));
        else if (r < 18) t.size = 3'($urandom_range(3, 7));
        else if (r < 26) t.sel = 0;
        else if (r < 34) t.trans = 2'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) t.trans[0] = 1'b1;
        return t;
    endfunction

    task automatic drive(xfer_t t);
        bus.HSEL = t.sel; bus.HTRANS = t.trans; bus.HADDR = t.addr;
        bus.HWRITE = t.wr; bus.HSIZE = t.size;
        bus.HBURST = 3'($urandom); bus.HPROT = 4'($urandom); bus.HMASTERLOCK = 1'($urandom);
    endtask

    // One bus cycle, entered at the negedge: check this cycle's response, then set up the next.
    task automatic step();
        logic        rdy, resp;
        logic [31:0] rd;
        bit          done;
        xfer_t       nx;
        rdy = 1; resp = 0; rd = 0; done = 0;
        if (dv && is_err(dp)) begin
            rdy = age == 1; resp = 1; done = rdy;
        end else if (dv) begin
            rdy = age == W; done = rdy;
            if (done && !dp.wr) rd = word_at(dp.addr);
        end
        check("hreadyout", 32'(bus.HREADYOUT), 32'(rdy));
        check("hresp", 32'(bus.HRESP), 32'(resp));
        check("hrdata", bus.HRDATA, rd);
        bus.HREADYIN = rdy;
        bus.HWDATA = (dv && dp.wr) ? dp.wdata : $urandom;
        if (done && dp.wr && !is_err(dp)) commit(dp);
        if (rnd && dv && !rdy && $urandom_range(0, 9) == 0) begin
            HRESET = 1; bus.HTRANS = 2'b00; dv = 0;
        end else begin
            HRESET = 0;
            if (rdy) begin
                nx = q.size() > 0 ? q.pop_front() : rnd ? rand_x() : idle_x;
                drive(nx);
                dp = nx; dv = nx.sel && nx.trans[1]; age = 0;
            end else begin
                age++;
                if (is_err(dp) && $urandom_range(0, 1) == 1) bus.HTRANS = 2'b00;
            end
        end
        @(negedge HCLK);
    endtask

    initial begin
        xfer_t t;
        idle_x = mk(0, 0, 2, 0); idle_x.sel = 0; idle_x.trans = 2'b00;
        drive(idle_x);
        bus.HREADYIN = 1; bus.HWDATA = 0;
        dv = 0; rnd = 0; age = 0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("rst_hresp", 32'(bus.HRESP), 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        for (int i = 0; i < DEPTH; i++) q.push_back(mk(1, 32'(i * 4), 2, $urandom));
        q.push_back(mk(1, 32'h10, 2, 32'hDEADBEEF));
        q.push_back(mk(0, 32'h10, 2, 0));
        q.push_back(mk(1, 32'h20, 2, 32'h11223344));
        q.push_back(mk(1, 32'h23, 0, 32'hAA00_0000));
        q.push_back(mk(0, 32'h20, 2, 0));
        q.push_back(mk(1, 32'h20, 1, 32'h0000_5566));
        q.push_back(mk(0, 32'h20, 2, 0));
        q.push_back(mk(1, 32'h30, 2, 32'hCAFEF00D));
        q.push_back(mk(0, 32'h30, 2, 0));
        q.push_back(mk(0, 32'h400, 2, 0));
        q.push_back(mk(1, 32'h400, 2, 32'h12345678));
        q.push_back(mk(0, 32'h0, 2, 0));
        q.push_back(mk(0, 32'h02, 2, 0));
        q.push_back(mk(1, 32'h01, 1, 32'hFFFF_FFFF));
        q.push_back(mk(0, 32'h0, 3, 0));
        q.push_back(mk(0, 32'h0, 2, 0));
        q.push_back(mk(0, 32'h3FC, 2, 0));
        t = mk(1, 32'h10, 2, 32'h0BAD_0BAD); t.sel = 0;
        q.push_back(t);
        q.push_back(mk(0, 32'h10, 2, 0));
        for (int i = 0; i < 2000 && q.size() > 0; i++) step();
        repeat (6) step();
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        repeat (8) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
